sdp_ram_byte_clear: RTL and testbench

- Single-clock simple dual-port RAM: one write port, one read port.
- Parametrised in data width, depth and byte size, with per-byte write enables and selectable read-during-write behaviour.
- Built-in clear sequencer fills every word with INIT_VALUE after reset or on request; `busy` is high while it runs.
- Used as a generic on-chip buffer for packet and line stores in single-clock datapaths.

---
 rtl/sdp_ram_byte_clear_if.sv | 34 +++
 rtl/sdp_ram_byte_clear.sv | 138 +++++++++++++
 tb/tb_sdp_ram_byte_clear.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sdp_ram_byte_clear_if.sv
// Port bundle for sdp_ram_byte_clear: write port, read port, clear control, status.
// master = requester side, slave = RAM side. state_dbg mirrors the clear FSM state.
interface sdp_ram_byte_clear_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int BYTE_WIDTH = 8
);
  localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;

  // Requests are single-cycle strobes sampled on the rising edge; they are
  // accepted only while busy is low. rd_valid marks the cycle ram_out is new.
  logic                  en_w;
  logic [NUM_BYTES-1:0]  be;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [DATA_WIDTH-1:0] data;
  logic                  en_r;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic                  clear_req;
  logic [DATA_WIDTH-1:0] ram_out;
  logic                  rd_valid;
  logic                  busy;
  logic                  clear_done;
  logic                  state_dbg;

  modport master (
    output en_w, be, write_addr, data, en_r, read_addr, clear_req,
    input  ram_out, rd_valid, busy, clear_done, state_dbg
  );

  modport slave (
    input  en_w, be, write_addr, data, en_r, read_addr, clear_req,
    output ram_out, rd_valid, busy, clear_done, state_dbg
  );
endinterface

// File: rtl/sdp_ram_byte_clear.sv
// Single-clock simple dual-port RAM with byte enables and a clear sequencer.
// Optional macro SDP_RAM_OUT_REG_EN adds an output register (read latency 2).
module sdp_ram_byte_clear #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    BYTE_WIDTH = 8,
  parameter int                    RDW_MODE   = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  sdp_ram_byte_clear_if.slave  bus
);
  localparam int DEPTH     = 2 ** ADDR_WIDTH;
  localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;

  typedef enum logic {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_vld_q, rd_vld_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  wr_fire;
  logic                  rd_fire;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] wr_mask;
  logic [DATA_WIDTH-1:0] rd_word;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    wr_fire = 1'b0;
    rd_fire = 1'b0;
    wr_addr = bus.write_addr;
    wr_data = bus.data;
    wr_mask = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      wr_mask[i*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{bus.be[i]}};
    end

    case (state_q)
      ST_CLEAR: begin
        wr_fire = 1'b1;
        wr_addr = cnt_q;
        wr_data = INIT_VALUE;
        wr_mask = '1;
        cnt_d   = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
          state_d = ST_READY;
          done_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      ST_READY: begin
        // A clear request drops any access presented in the same cycle.
        if (bus.clear_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else begin
          wr_fire = bus.en_w;
          rd_fire = bus.en_r;
        end
      end
      default: state_d = ST_CLEAR;
    endcase

    rd_word = mem_q[bus.read_addr];
    if ((RDW_MODE != 0) && wr_fire && (wr_addr == bus.read_addr)) begin
      rd_word = (rd_word & ~wr_mask) | (wr_data & wr_mask);
    end

    rd_data_d = rd_fire ? rd_word : rd_data_q;
    rd_vld_d  = rd_fire;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      rd_data_q <= rd_data_d;
      rd_vld_q  <= rd_vld_d;
    end
  end

  // Storage has no reset; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (wr_fire && !reset) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (wr_mask[i*BYTE_WIDTH]) begin
          mem_q[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

`ifdef SDP_RAM_OUT_REG_EN
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  out_vld_q, out_vld_d;

  always_comb begin
    out_d     = rd_vld_q ? rd_data_q : out_q;
    out_vld_d = rd_vld_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign bus.ram_out  = out_q;
  assign bus.rd_valid = out_vld_q;
`else
  assign bus.ram_out  = rd_data_q;
  assign bus.rd_valid = rd_vld_q;
`endif

  assign bus.busy       = (state_q == ST_CLEAR);
  assign bus.clear_done = done_q;
  assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_sdp_ram_byte_clear.sv
// Directed bench for sdp_ram_byte_clear: two instances (old-data and new-data
// read-during-write) driven identically, read results checked from expected queues.
module tb_sdp_ram_byte_clear;
  localparam int W  = 16;
  localparam int AW = 4;
  localparam int BW = 8;
`ifdef SDP_RAM_OUT_REG_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;

  int compared   = 0;
  int mismatched = 0;

  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  int           cyc_q0[$];
  int           cyc_q1[$];

  sdp_ram_byte_clear_if #(.DATA_WIDTH(W), .ADDR_WIDTH(AW), .BYTE_WIDTH(BW)) bus0 ();
  sdp_ram_byte_clear_if #(.DATA_WIDTH(W), .ADDR_WIDTH(AW), .BYTE_WIDTH(BW)) bus1 ();

  sdp_ram_byte_clear #(
    .DATA_WIDTH(W), .ADDR_WIDTH(AW), .BYTE_WIDTH(BW), .RDW_MODE(0), .INIT_VALUE(16'h0000)
  ) u_dut0 (.clk(clk), .reset(reset), .bus(bus0));

  sdp_ram_byte_clear #(
    .DATA_WIDTH(W), .ADDR_WIDTH(AW), .BYTE_WIDTH(BW), .RDW_MODE(1), .INIT_VALUE(16'h0000)
  ) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic ew, input logic [1:0] b, input logic [AW-1:0] wa,
                       input logic [W-1:0] d, input logic er, input logic [AW-1:0] ra,
                       input logic clr);
    bus0.en_w = ew; bus0.be = b; bus0.write_addr = wa; bus0.data = d;
    bus0.en_r = er; bus0.read_addr = ra; bus0.clear_req = clr;
    bus1.en_w = ew; bus1.be = b; bus1.write_addr = wa; bus1.data = d;
    bus1.en_r = er; bus1.read_addr = ra; bus1.clear_req = clr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 2'b00, '0, '0, 1'b0, '0, 1'b0);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push_exp(input logic [W-1:0] e0, input logic [W-1:0] e1);
    exp_q0.push_back(e0); cyc_q0.push_back(cyc + RD_LAT);
    exp_q1.push_back(e1); cyc_q1.push_back(cyc + RD_LAT);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [1:0] b, input logic [W-1:0] d);
    drive(1'b1, b, a, d, 1'b0, '0, 1'b0);
    step();
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [W-1:0] e0, input logic [W-1:0] e1);
    drive(1'b0, 2'b00, '0, '0, 1'b1, a, 1'b0);
    push_exp(e0, e1);
    step();
  endtask

  task automatic do_rw(input logic [AW-1:0] wa, input logic [1:0] b, input logic [W-1:0] d,
                       input logic [AW-1:0] ra, input logic [W-1:0] e0, input logic [W-1:0] e1);
    drive(1'b1, b, wa, d, 1'b1, ra, 1'b0);
    push_exp(e0, e1);
    step();
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    logic [W-1:0] d;
    int           c;
    forever begin
      @(negedge clk);
      if (bus0.rd_valid === 1'b1) begin
        if (exp_q0.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL rd0_unexpected: got rd_valid=1 data=%0h, required no read", bus0.ram_out);
        end else begin
          d = exp_q0.pop_front(); c = cyc_q0.pop_front();
          chk("rd0_data", bus0.ram_out, d);
          chk("rd0_cycle", cyc, c);
        end
      end
      if (bus1.rd_valid === 1'b1) begin
        if (exp_q1.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL rd1_unexpected: got rd_valid=1 data=%0h, required no read", bus1.ram_out);
        end else begin
          d = exp_q1.pop_front(); c = cyc_q1.pop_front();
          chk("rd1_data", bus1.ram_out, d);
          chk("rd1_cycle", cyc, c);
        end
      end
    end
  endtask

  // Counts busy cycles from the next falling edge; optionally pokes a read and a
  // repeated clear request while busy, both of which must be ignored.
  task automatic wait_clear(input bit poke);
    int n;
    int early_done;
    n = 0;
    early_done = 0;
    @(negedge clk);
    while (bus0.busy === 1'b1 && n < 40) begin
      n++;
      if (bus0.clear_done === 1'b1 || bus1.clear_done === 1'b1) early_done++;
      if (poke && n == 2) drive(1'b0, 2'b00, '0, '0, 1'b1, 4'd3, 1'b1);
      if (poke && n == 4) drive(1'b0, 2'b00, '0, '0, 1'b0, '0, 1'b0);
      @(negedge clk);
    end
    chk("busy_cycles", n, 16);
    chk("busy1_idle", bus1.busy, 1'b0);
    chk("done_during_busy", early_done, 0);
    chk("clear_done0", bus0.clear_done, 1'b1);
    chk("clear_done1", bus1.clear_done, 1'b1);
    @(negedge clk);
    chk("clear_done0_pulse", bus0.clear_done, 1'b0);
    chk("clear_done1_pulse", bus1.clear_done, 1'b0);
    chk("busy_after", bus0.busy, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    drive(1'b0, 2'b00, '0, '0, 1'b0, '0, 1'b0);
    fork
      monitor();
    join_none

    // Reset held for three cycles.
    step();
    @(negedge clk);
    chk("rst_busy0", bus0.busy, 1'b1);
    chk("rst_busy1", bus1.busy, 1'b1);
    chk("rst_rd_valid0", bus0.rd_valid, 1'b0);
    chk("rst_ram_out0", bus0.ram_out, 16'h0000);
    chk("rst_ram_out1", bus1.ram_out, 16'h0000);
    chk("rst_clear_done0", bus0.clear_done, 1'b0);
    step();
    step();
    reset = 1'b0;
    wait_clear(1'b0);

    // Cleared contents, back-to-back reads.
    for (int a = 0; a < 16; a++) do_read(AW'(a), 16'h0000, 16'h0000);
    idle(3);

    // Byte-enable merge.
    do_write(4'd5, 2'b01, 16'hA5C3);
    do_write(4'd5, 2'b10, 16'h1200);
    do_read(4'd5, 16'h12C3, 16'h12C3);
    do_write(4'd5, 2'b00, 16'hFFFF);
    do_read(4'd5, 16'h12C3, 16'h12C3);
    idle(2);

    // Same-address read during write: old data vs merged new data.
    do_write(4'd7, 2'b11, 16'h1111);
    do_rw(4'd7, 2'b11, 16'h2222, 4'd7, 16'h1111, 16'h2222);
    do_read(4'd7, 16'h2222, 16'h2222);
    do_write(4'd7, 2'b10, 16'hAB00);
    do_rw(4'd7, 2'b01, 16'h00CD, 4'd7, 16'hAB22, 16'hABCD);
    idle(2);

    // Independent addresses in one cycle.
    do_rw(4'd8, 2'b11, 16'h3344, 4'd5, 16'h12C3, 16'h12C3);
    do_read(4'd8, 16'h3344, 16'h3344);
    idle(4);
    @(negedge clk);
    chk("hold_ram_out0", bus0.ram_out, 16'h3344);
    chk("hold_ram_out1", bus1.ram_out, 16'h3344);
    step();

    // Clear request beats a simultaneous read and write.
    do_write(4'd3, 2'b11, 16'hBEEF);
    do_read(4'd3, 16'hBEEF, 16'hBEEF);
    idle(2);
    drive(1'b1, 2'b11, 4'd4, 16'hFFFF, 1'b1, 4'd3, 1'b1);
    step();
    drive(1'b0, 2'b00, '0, '0, 1'b0, '0, 1'b0);
    wait_clear(1'b1);
    do_read(4'd3, 16'h0000, 16'h0000);
    do_read(4'd4, 16'h0000, 16'h0000);
    do_read(4'd8, 16'h0000, 16'h0000);
    idle(3);

    // Reset in the middle of a clear restarts it from the beginning.
    do_write(4'd9, 2'b11, 16'h5A5A);
    drive(1'b0, 2'b00, '0, '0, 1'b0, '0, 1'b1);
    step();
    drive(1'b0, 2'b00, '0, '0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 9; i++) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_busy0", bus0.busy, 1'b1);
    step();
    step();
    reset = 1'b0;
    wait_clear(1'b0);
    do_read(4'd9, 16'h0000, 16'h0000);
    do_read(4'd0, 16'h0000, 16'h0000);

    // Consecutive reads after fresh writes, data in order.
    do_write(4'd1, 2'b11, 16'h0101);
    do_write(4'd2, 2'b11, 16'h0202);
    do_write(4'd3, 2'b11, 16'h0303);
    do_read(4'd1, 16'h0101, 16'h0101);
    do_read(4'd2, 16'h0202, 16'h0202);
    do_read(4'd3, 16'h0303, 16'h0303);
    idle(6);

    chk("exp_q0_drained", exp_q0.size(), 0);
    chk("exp_q1_drained", exp_q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
